// File: rtl/copper_fetch.sv
// copper_fetch: copper instruction prefetcher with dual 16-bit banks and a 3-entry registered-head FIFO
module copper_fetch #(
  parameter int AWIDTH = 10,
  parameter int DEPTH  = 3
) (
  input  logic              clk,
  input  logic              reset_n_i,
  input  logic              load_i,
  input  logic [AWIDTH-1:0] load_addr_i,
  input  logic              stop_i,
  output logic              rd_en_o,
  output logic [AWIDTH-1:0] rd_address_o,
  input  logic [15:0]       even_data_i,
  input  logic [15:0]       odd_data_i,
  output logic              instr_valid_o,
  output logic [31:0]       instr_o,
  output logic [AWIDTH-1:0] instr_addr_o,
  input  logic              instr_ready_i,
  output logic              active_o
);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [AWIDTH-1:0] pc, last_addr;
  logic [CW-1:0] count, count_n;
  logic infl, issue, flush, push, pop;
  logic [AWIDTH+31:0] mem [DEPTH];
  always_ff @(posedge clk)
    state <= !reset_n_i ? IDLE : state_n;
  always_comb begin
    flush = load_i | stop_i;
    state_n = stop_i ? IDLE : load_i ? RUN : state;
    issue = reset_n_i && state == RUN && !flush &&
            ({1'b0, count} + (CW+1)'(infl) < (CW+1)'(DEPTH));
    push = infl && !flush;
    pop = count != '0 && instr_ready_i && !flush;
    count_n = flush ? '0 : count + CW'(push) - CW'(pop);
    rd_en_o = issue;
    rd_address_o = issue ? pc : last_addr;
    active_o = state == RUN;
    instr_valid_o = count != '0;
    {instr_addr_o, instr_o} = mem[0];
  end
  // last_addr is the issuing PC, so it also tags the data returning next cycle
  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      pc <= '0;
      last_addr <= '0;
      count <= '0;
      infl <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      infl <= issue;
      count <= count_n;
      if (load_i && !stop_i) pc <= load_addr_i;
      else if (issue) pc <= pc + AWIDTH'(1);
      if (issue) last_addr <= pc;
      if (pop) for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      if (push) mem[count - CW'(pop)] <= {last_addr, even_data_i, odd_data_i};
    end
  end
endmodule

// File: tb/tb_copper_fetch.sv
// tb_copper_fetch: directed stimulus with a scoreboard queue checked by an independent monitor
module tb_copper_fetch;
  logic clk = 0, reset_n = 0, load = 0, stop = 0, ready = 0;
  logic [9:0] load_addr = '0;
  logic rd_en, valid, active;
  logic [9:0] rd_address, instr_addr;
  logic [15:0] even_data = '0, odd_data = '0;
  logic [31:0] instr;
  logic [41:0] exp_q[$];
  logic pend_en = 0;
  logic [9:0] pend_a = '0;
  int total = 0, bad = 0, issued = 0;

  copper_fetch dut (
    .clk(clk), .reset_n_i(reset_n), .load_i(load), .load_addr_i(load_addr), .stop_i(stop),
    .rd_en_o(rd_en), .rd_address_o(rd_address), .even_data_i(even_data), .odd_data_i(odd_data),
    .instr_valid_o(valid), .instr_o(instr), .instr_addr_o(instr_addr),
    .instr_ready_i(ready), .active_o(active));

  always #5 clk = ~clk;

  // bank model: even = zero-extended address, odd = its complement, one cycle after rd_en
  always @(negedge clk) begin
    pend_en = rd_en;
    pend_a = rd_address;
    if (rd_en) issued++;
  end
  always @(posedge clk)
    if (pend_en) begin
      even_data <= {6'b0, pend_a};
      odd_data <= ~{6'b0, pend_a};
    end

  function automatic logic [41:0] ent(input logic [9:0] a);
    return {a, 6'b0, a, ~{6'b0, a}};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  always @(negedge clk)
    if (reset_n && valid && ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop: got %0h want none", {instr_addr, instr});
      end else chk("head", {22'b0, instr_addr, instr}, {22'b0, exp_q.pop_front()});
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [9:0] a);
    load_addr = a;
    load = 1;
    tick();
    load = 0;
  endtask

  task automatic do_stop;
    stop = 1;
    tick();
    stop = 0;
    @(negedge clk);
    chk("stop_active", active, 0);
    chk("stop_valid", valid, 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic stream(input logic [9:0] a, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(ent(a + 10'(i)));
    ready = 1;
    pulse_load(a);
    @(negedge clk);
    chk("rd_en_n1", rd_en, 1);
    chk("rd_addr_n1", rd_address, a);
    @(negedge clk);
    chk("valid_n2", valid, 0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("no_bubble", valid, 1);
    end
    @(posedge clk);
    #1;
    ready = 0;
    do_stop();
  endtask

  initial begin
    tick();
    tick();
    @(negedge clk);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_address, 0);
    chk("rst_valid", valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_addr", instr_addr, 0);
    chk("rst_active", active, 0);
    @(posedge clk);
    #1;
    reset_n = 1;
    tick();
    // sequential stream and PC wrap
    stream(10'h010, 8);
    stream(10'h3FE, 4);
    // backpressure: exactly three reads, then drain without gaps
    for (int i = 0; i < 4; i++) exp_q.push_back(ent(10'(i)));
    issued = 0;
    pulse_load(10'h000);
    repeat (9) tick();
    @(negedge clk);
    chk("bp_issued", issued, 3);
    chk("bp_rd_en", rd_en, 0);
    chk("bp_head", instr_addr, 10'h000);
    chk("bp_valid", valid, 1);
    @(posedge clk);
    #1;
    ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_no_gap", valid, 1);
    end
    @(posedge clk);
    #1;
    ready = 0;
    do_stop();
    // reload while full flushes stale entries
    pulse_load(10'h200);
    repeat (6) tick();
    @(negedge clk);
    chk("full_head", instr_addr, 10'h200);
    exp_q.push_back(ent(10'h100));
    exp_q.push_back(ent(10'h101));
    @(posedge clk);
    #1;
    pulse_load(10'h100);
    ready = 1;
    @(negedge clk);
    chk("flush_valid_n1", valid, 0);
    @(negedge clk);
    chk("flush_valid_n2", valid, 0);
    @(negedge clk);
    chk("reload_valid_n3", valid, 1);
    @(negedge clk);
    @(posedge clk);
    #1;
    ready = 0;
    do_stop();
    // load and stop together: stop wins
    pulse_load(10'h020);
    repeat (4) tick();
    load_addr = 10'h300;
    load = 1;
    stop = 1;
    tick();
    load = 0;
    stop = 0;
    issued = 0;
    @(negedge clk);
    chk("ls_active", active, 0);
    chk("ls_valid", valid, 0);
    chk("ls_rd_en", rd_en, 0);
    chk("ls_rd_addr_hold", rd_address, 10'h022);
    repeat (5) tick();
    @(negedge clk);
    chk("ls_no_reads", issued, 0);
    // reset while a read is in flight
    @(posedge clk);
    #1;
    pulse_load(10'h040);
    tick();
    reset_n = 0;
    tick();
    reset_n = 1;
    @(negedge clk);
    chk("mrst_rd_en", rd_en, 0);
    chk("mrst_rd_addr", rd_address, 0);
    chk("mrst_valid", valid, 0);
    chk("mrst_instr", instr, 0);
    chk("mrst_instr_addr", instr_addr, 0);
    chk("mrst_active", active, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mrst_no_push", valid, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
